// File: rtl/assoc_cache_pkg.sv
// Shared encodings and pLRU helpers for the set-associative lookup cache.
package assoc_cache_pkg;

   localparam logic [1:0] OP_LOOKUP = 2'd0;
   localparam logic [1:0] OP_WRITE  = 2'd1;
   localparam logic [1:0] OP_INVAL  = 2'd2;

   typedef enum logic [1:0] {ST_FLUSH, ST_RUN, ST_STALL} state_e;

   // A way entry is packed as {valid, tag, data}; valid is the MSB.
   function automatic int entry_width(input int tag_w, input int data_w);
      return 1 + tag_w + data_w;
   endfunction

   // Tree pLRU: each bit points at the side holding the next victim.
   // 4-way: bit0 = root, bit1 = ways 0/1, bit2 = ways 2/3.
   function automatic logic [2:0] plru_update(input logic [2:0] s, input logic [1:0] way,
                                              input int nway);
      logic [2:0] r;
      r = s;
      if (nway == 2) begin
         r[0] = ~way[0];
      end else if (nway == 4) begin
         r[0] = ~way[1];
         if (way[1]) r[2] = ~way[0];
         else        r[1] = ~way[0];
      end
      return r;
   endfunction

   function automatic logic [1:0] plru_victim(input logic [2:0] s, input int nway);
      logic [1:0] v;
      v = 2'b00;
      if (nway == 2)      v = {1'b0, s[0]};
      else if (nway == 4) v = s[0] ? {1'b1, s[2]} : {1'b0, s[1]};
      return v;
   endfunction

endpackage

// File: rtl/assoc_cache_way_ram.sv
// One way of the cache: simple dual-port RAM, registered read, read-first.
module assoc_cache_way_ram #(
   parameter int AW = 8,
   parameter int DW = 8
) (
   input  logic          clk,
   input  logic          wr_en_i,
   input  logic [AW-1:0] wr_addr_i,
   input  logic [DW-1:0] wr_data_i,
   input  logic [AW-1:0] rd_addr_i,
   output logic [DW-1:0] rd_data_o
);

   logic [DW-1:0] mem_q [2**AW];
   logic [DW-1:0] rd_q;

   // Write and read in the same edge; a colliding read returns the old word.
   always_ff @(posedge clk) begin
      if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
      rd_q <= mem_q[rd_addr_i];
   end

   assign rd_data_o = rd_q;

endmodule

// File: rtl/assoc_cache.sv
// N-way set-associative lookup cache: 3-stage pipeline, tree pLRU, flush sweep.
module assoc_cache
   import assoc_cache_pkg::*;
#(
   parameter int C_ADDR_WIDTH = 32,
   parameter int C_SET_WIDTH  = 8,
   parameter int C_DATA_WIDTH = 512,
   parameter int C_NWAY       = 2,
   parameter int C_TAG_WIDTH  = C_ADDR_WIDTH - C_SET_WIDTH,
   localparam int WAY_W       = (C_NWAY > 1) ? $clog2(C_NWAY) : 1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    flush,
   output logic                    busy,
   input  logic                    req_valid,
   output logic                    req_ready,
   input  logic [1:0]              req_op,
   input  logic [C_ADDR_WIDTH-1:0] req_addr,
   input  logic [C_DATA_WIDTH-1:0] req_data,
   output logic                    rsp_valid,
   output logic [1:0]              rsp_op,
   output logic                    rsp_hit,
   output logic [WAY_W-1:0]        rsp_way,
   output logic [C_DATA_WIDTH-1:0] rsp_data,
   output logic                    rsp_evict
);

   localparam int NSET    = 2**C_SET_WIDTH;
   localparam int PLRU_W  = (C_NWAY > 1) ? C_NWAY - 1 : 1;
   localparam int ENTRY_W = entry_width(C_TAG_WIDTH, C_DATA_WIDTH);

   if (C_NWAY != 1 && C_NWAY != 2 && C_NWAY != 4) begin : g_bad_nway
      $error("assoc_cache: C_NWAY must be 1, 2 or 4");
   end

   typedef struct packed {
      logic                    vld;
      logic [C_TAG_WIDTH-1:0]  tag;
      logic [C_DATA_WIDTH-1:0] data;
   } entry_t;

   typedef struct packed {
      logic [1:0]              op;
      logic [C_ADDR_WIDTH-1:0] addr;
      logic [C_DATA_WIDTH-1:0] data;
   } cmd_t;

   state_e                          state_q, state_d;
   logic [C_SET_WIDTH-1:0]          cnt_q, cnt_d;
   logic                            pend_q, pend_d;
   logic [2:0]                      vld_pipe_q;
   cmd_t                            p0_q, p1_q;
   logic [PLRU_W-1:0]               plru_q [NSET];
   logic                            accept, sweep;

   logic [C_NWAY-1:0]               wr_en;
   logic [C_SET_WIDTH-1:0]          wr_addr;
   entry_t                          wr_ent;
   logic [C_NWAY-1:0][ENTRY_W-1:0]  rd_raw;

   logic [C_SET_WIDTH-1:0]          idx1;
   logic [C_TAG_WIDTH-1:0]          tag1;
   logic                            s1_vld, is_wr, is_inv, is_lk;
   logic                            hit, any_inv, evict, plru_we;
   logic [WAY_W-1:0]                hit_way, inv_way, victim, way_sel;
   logic [C_DATA_WIDTH-1:0]         hit_data;
   logic [2:0]                      plru_cur;
   logic [PLRU_W-1:0]               plru_nxt;

   logic [1:0]                      rsp_op_q;
   logic                            rsp_hit_q, rsp_evict_q;
   logic [WAY_W-1:0]                rsp_way_q;
   logic [C_DATA_WIDTH-1:0]         rsp_data_q;

   for (genvar w = 0; w < C_NWAY; w++) begin : g_way
      assoc_cache_way_ram #(.AW(C_SET_WIDTH), .DW(ENTRY_W)) u_ram (
         .clk       (clk),
         .wr_en_i   (wr_en[w]),
         .wr_addr_i (wr_addr),
         .wr_data_i (wr_ent),
         .rd_addr_i (p0_q.addr[C_SET_WIDTH-1:0]),
         .rd_data_o (rd_raw[w])
      );
   end

   assign accept = req_valid && req_ready;

   // Control state: FSM, shared sweep/stall counter, deferred flush, stage valids.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_FLUSH;
         cnt_q      <= '0;
         pend_q     <= 1'b0;
         vld_pipe_q <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         pend_q     <= pend_d;
         vld_pipe_q <= {vld_pipe_q[1:0], accept};
      end
   end

   // Next state: a flush request waits until S0/S1 are empty before sweeping.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      pend_d    = pend_q;
      req_ready = 1'b0;
      busy      = 1'b0;
      sweep     = 1'b0;
      unique case (state_q)
         ST_FLUSH: begin
            busy  = 1'b1;
            sweep = 1'b1;
            cnt_d = cnt_q + 1'b1;
            if (&cnt_q) begin
               state_d = ST_RUN;
               cnt_d   = '0;
            end
         end
         ST_RUN: begin
            if (flush || pend_q) begin
               pend_d = 1'b1;
               if (vld_pipe_q[1:0] == 2'b00) begin
                  state_d = ST_FLUSH;
                  cnt_d   = '0;
                  pend_d  = 1'b0;
               end
            end else begin
               req_ready = 1'b1;
               if (req_valid && (req_op == OP_WRITE || req_op == OP_INVAL)) begin
                  state_d = ST_STALL;
                  cnt_d   = '0;
               end
            end
         end
         ST_STALL: begin
            if (flush) pend_d = 1'b1;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q[0]) begin
               state_d = ST_RUN;
               cnt_d   = '0;
            end
         end
         default: state_d = ST_FLUSH;
      endcase
   end

   // Command payload through S0/S1; qualified by vld_pipe_q so no reset needed.
   always_ff @(posedge clk) begin
      if (accept) p0_q <= '{op: req_op, addr: req_addr, data: req_data};
      p1_q <= p0_q;
   end

   assign s1_vld = vld_pipe_q[1];
   assign idx1   = p1_q.addr[C_SET_WIDTH-1:0];
   assign tag1   = p1_q.addr[C_ADDR_WIDTH-1:C_SET_WIDTH];
   assign is_wr  = (p1_q.op == OP_WRITE);
   assign is_inv = (p1_q.op == OP_INVAL);
   assign is_lk  = !is_wr && !is_inv;

   // S1 tag compare; scanning high to low makes the lowest index win.
   always_comb begin
      entry_t e;
      e        = '0;
      hit      = 1'b0;
      hit_way  = '0;
      hit_data = '0;
      any_inv  = 1'b0;
      inv_way  = '0;
      for (int w = C_NWAY - 1; w >= 0; w--) begin
         e = entry_t'(rd_raw[w]);
         if (e.vld && e.tag == tag1) begin
            hit      = 1'b1;
            hit_way  = WAY_W'(w);
            hit_data = e.data;
         end
         if (!e.vld) begin
            any_inv = 1'b1;
            inv_way = WAY_W'(w);
         end
      end
      plru_cur = 3'(plru_q[idx1]);
      victim   = WAY_W'(plru_victim(plru_cur, C_NWAY));
      way_sel  = hit_way;
      if (is_wr && !hit) way_sel = any_inv ? inv_way : victim;
      evict    = is_wr && !hit && !any_inv;
      plru_we  = s1_vld && (is_wr || (is_lk && hit));
      plru_nxt = PLRU_W'(plru_update(plru_cur, 2'(way_sel), C_NWAY));
   end

   // RAM write port: sweep clears every way, otherwise S1 fill or invalidate.
   always_comb begin
      wr_en   = '0;
      wr_addr = idx1;
      wr_ent  = '0;
      if (sweep) begin
         wr_en   = '1;
         wr_addr = cnt_q;
      end else if (s1_vld && is_wr) begin
         wr_en[way_sel] = 1'b1;
         wr_ent         = '{vld: 1'b1, tag: tag1, data: p1_q.data};
      end else if (s1_vld && is_inv && hit) begin
         wr_en[way_sel] = 1'b1;
      end
   end

   // pLRU bits: zeroed by the sweep, updated by S1 hits and fills.
   always_ff @(posedge clk) begin
      if (sweep)        plru_q[cnt_q] <= '0;
      else if (plru_we) plru_q[idx1]  <= plru_nxt;
   end

   // S2 response register; fields are zero whenever no response is issued.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_op_q    <= '0;
         rsp_hit_q   <= 1'b0;
         rsp_way_q   <= '0;
         rsp_evict_q <= 1'b0;
         rsp_data_q  <= '0;
      end else begin
         rsp_op_q    <= s1_vld ? p1_q.op : 2'b00;
         rsp_hit_q   <= s1_vld && hit;
         rsp_way_q   <= s1_vld ? way_sel : '0;
         rsp_evict_q <= s1_vld && evict;
         rsp_data_q  <= (s1_vld && is_lk && hit) ? hit_data : '0;
      end
   end

   assign rsp_valid = vld_pipe_q[2];
   assign rsp_op    = rsp_op_q;
   assign rsp_hit   = rsp_hit_q;
   assign rsp_way   = rsp_way_q;
   assign rsp_evict = rsp_evict_q;
   assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_assoc_cache.sv
// Directed bench for assoc_cache at default geometry (256 sets, 2 ways, 512-bit data).
module tb_assoc_cache;
   import assoc_cache_pkg::*;

   logic         clk = 1'b0;
   logic         rst_n, flush, busy, req_valid, req_ready;
   logic [1:0]   req_op, rsp_op;
   logic [31:0]  req_addr;
   logic [511:0] req_data, rsp_data;
   logic         rsp_valid, rsp_hit, rsp_evict;
   logic [0:0]   rsp_way;

   int n_chk = 0;
   int n_pass = 0;

   assoc_cache dut (
      .clk(clk), .rst_n(rst_n), .flush(flush), .busy(busy),
      .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
      .req_addr(req_addr), .req_data(req_data),
      .rsp_valid(rsp_valid), .rsp_op(rsp_op), .rsp_hit(rsp_hit),
      .rsp_way(rsp_way), .rsp_data(rsp_data), .rsp_evict(rsp_evict)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   typedef struct {
      logic [1:0]   op;
      logic [31:0]  addr;
      logic [511:0] data;
      logic         hit;
      logic         way;
      logic         evict;
      logic [511:0] rdata;
   } vec_t;

   task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
   endtask

   function automatic vec_t mk(input logic [1:0] op, input logic [31:0] a, input logic [511:0] d,
                               input logic h, input logic w, input logic e, input logic [511:0] rd);
      vec_t v;
      v.op = op; v.addr = a; v.data = d; v.hit = h; v.way = w; v.evict = e; v.rdata = rd;
      return v;
   endfunction

   // Count negedges with busy high, optionally pulsing flush mid-sweep.
   task automatic count_busy(input string nm, input bit pulse, output int n, output int rsps);
      n = 0;
      rsps = 0;
      while (busy && n < 1000) begin
         n++;
         if (rsp_valid) rsps++;
         flush = pulse && (n == 100);
         @(negedge clk);
      end
      flush = 1'b0;
      chk({nm, " busy_cycles"}, 512'(n), 512'(256));
      chk({nm, " ready_after"}, 512'(req_ready), 512'(1));
   endtask

   // Issue one command and check the full response three negedges later.
   task automatic do_cmd(input string nm, input vec_t v);
      int n;
      logic [2:0] rdy;
      logic [1:0] early;
      n = 0;
      while (!req_ready && n < 100) begin @(negedge clk); n++; end
      chk({nm, " ready_wait"}, 512'(req_ready), 512'(1));
      req_valid = 1'b1; req_op = v.op; req_addr = v.addr; req_data = v.data;
      @(negedge clk);
      req_valid = 1'b0;
      rdy[0] = req_ready; early[0] = rsp_valid;
      @(negedge clk);
      rdy[1] = req_ready; early[1] = rsp_valid;
      @(negedge clk);
      rdy[2] = req_ready;
      chk({nm, " early_rsp"}, 512'(early), 512'(0));
      chk({nm, " rsp_valid"}, 512'(rsp_valid), 512'(1));
      chk({nm, " ready_pat"}, 512'(rdy),
          512'((v.op == OP_WRITE || v.op == OP_INVAL) ? 3'b100 : 3'b111));
      chk({nm, " op"},    512'(rsp_op),    512'(v.op));
      chk({nm, " hit"},   512'(rsp_hit),   512'(v.hit));
      chk({nm, " way"},   512'(rsp_way),   512'(v.way));
      chk({nm, " evict"}, 512'(rsp_evict), 512'(v.evict));
      chk({nm, " data"},  rsp_data,        v.rdata);
   endtask

   localparam logic [31:0] A_ADR = 32'h0000_1234;
   localparam logic [31:0] B_ADR = 32'h0000_5634;
   localparam logic [31:0] C_ADR = 32'h0000_9A34;
   localparam logic [31:0] D_ADR = 32'h0000_BC34;
   localparam logic [31:0] E_ADR = 32'h0000_DE34;

   initial begin
      logic [511:0] da, db, dc, d2, dd, z;
      vec_t vecs[17];
      vec_t b2b[8];
      int nb, nr;

      da = {64{8'hAB}};
      db = {16{32'hB0B0_0001}};
      dc = {16{32'hC0C0_0002}};
      d2 = {64{8'h77}};
      dd = {16{32'hDDDD_0003}};
      z  = '0;

      vecs[0]  = mk(OP_LOOKUP, A_ADR, z,  0, 0, 0, z);   // cold miss
      vecs[1]  = mk(OP_WRITE,  A_ADR, da, 0, 0, 0, z);   // fill way 0
      vecs[2]  = mk(OP_LOOKUP, A_ADR, z,  1, 0, 0, da);
      vecs[3]  = mk(OP_WRITE,  B_ADR, db, 0, 1, 0, z);   // lowest invalid = way 1
      vecs[4]  = mk(OP_LOOKUP, A_ADR, z,  1, 0, 0, da);  // A MRU, victim way 1
      vecs[5]  = mk(OP_WRITE,  C_ADR, dc, 0, 1, 1, z);   // C evicts B
      vecs[6]  = mk(OP_LOOKUP, B_ADR, z,  0, 0, 0, z);
      vecs[7]  = mk(OP_LOOKUP, A_ADR, z,  1, 0, 0, da);
      vecs[8]  = mk(OP_LOOKUP, C_ADR, z,  1, 1, 0, dc);
      vecs[9]  = mk(OP_WRITE,  A_ADR, d2, 1, 0, 0, z);   // in-place update
      vecs[10] = mk(OP_LOOKUP, A_ADR, z,  1, 0, 0, d2);
      vecs[11] = mk(OP_INVAL,  A_ADR, z,  1, 0, 0, z);
      vecs[12] = mk(OP_LOOKUP, A_ADR, z,  0, 0, 0, z);
      vecs[13] = mk(OP_INVAL,  A_ADR, z,  0, 0, 0, z);   // second inval misses
      vecs[14] = mk(2'd3,      C_ADR, z,  1, 1, 0, dc);  // reserved op acts as lookup
      vecs[15] = mk(OP_WRITE,  D_ADR, dd, 0, 0, 0, z);   // reuses invalidated way 0
      vecs[16] = mk(OP_INVAL,  32'h0000_0035, z, 0, 0, 0, z);

      b2b[0] = mk(OP_LOOKUP, A_ADR, z, 0, 0, 0, z);
      b2b[1] = mk(OP_LOOKUP, C_ADR, z, 1, 1, 0, dc);
      b2b[2] = mk(OP_LOOKUP, D_ADR, z, 1, 0, 0, dd);
      b2b[3] = mk(OP_LOOKUP, B_ADR, z, 0, 0, 0, z);
      b2b[4] = mk(OP_LOOKUP, 32'h0000_0035, z, 0, 0, 0, z);
      b2b[5] = mk(OP_LOOKUP, C_ADR, z, 1, 1, 0, dc);
      b2b[6] = mk(OP_LOOKUP, D_ADR, z, 1, 0, 0, dd);
      b2b[7] = mk(OP_LOOKUP, 32'h0000_0034, z, 0, 0, 0, z);

      rst_n = 1'b0; flush = 1'b0; req_valid = 1'b0;
      req_op = '0; req_addr = '0; req_data = '0;
      repeat (3) @(negedge clk);

      // Reset values
      chk("rst req_ready", 512'(req_ready), 512'(0));
      chk("rst busy",      512'(busy),      512'(1));
      chk("rst rsp_valid", 512'(rsp_valid), 512'(0));
      chk("rst rsp_fields", 512'({rsp_op, rsp_hit, rsp_way, rsp_evict}), 512'(0));
      chk("rst rsp_data",  rsp_data, z);

      rst_n = 1'b1;
      count_busy("cold", 1'b0, nb, nr);

      for (int i = 0; i < 17; i++) do_cmd($sformatf("v%0d", i), vecs[i]);

      // Back-to-back lookups: one accept per cycle, responses in order 2 cycles later.
      req_valid = 1'b1; req_op = OP_LOOKUP; req_addr = b2b[0].addr;
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         if (k < 8) begin
            chk($sformatf("b2b ready k%0d", k), 512'(req_ready), 512'(1));
            req_addr = b2b[k].addr;
         end else begin
            req_valid = 1'b0;
         end
         if (k >= 3) begin
            chk($sformatf("b2b%0d valid", k - 3), 512'(rsp_valid), 512'(1));
            chk($sformatf("b2b%0d hit", k - 3),  512'(rsp_hit), 512'(b2b[k-3].hit));
            chk($sformatf("b2b%0d way", k - 3),  512'(rsp_way), 512'(b2b[k-3].way));
            chk($sformatf("b2b%0d data", k - 3), rsp_data, b2b[k-3].rdata);
         end else begin
            chk($sformatf("b2b early k%0d", k), 512'(rsp_valid), 512'(0));
         end
      end
      @(negedge clk);
      chk("b2b tail", 512'(rsp_valid), 512'(0));

      // Flush mid-stream: two lookups in flight drain, third is refused.
      req_valid = 1'b1; req_op = OP_LOOKUP; req_addr = C_ADR;
      @(negedge clk);
      req_addr = D_ADR;
      @(negedge clk);
      flush = 1'b1; req_addr = C_ADR;
      #1;
      chk("flush ready_drop", 512'(req_ready), 512'(0));
      @(negedge clk);
      flush = 1'b0; req_valid = 1'b0;
      chk("flush rsp0 valid", 512'(rsp_valid), 512'(1));
      chk("flush rsp0 data",  rsp_data, dc);
      @(negedge clk);
      chk("flush rsp1 valid", 512'(rsp_valid), 512'(1));
      chk("flush rsp1 data",  rsp_data, dd);
      @(negedge clk);
      chk("flush no_rsp", 512'(rsp_valid), 512'(0));
      chk("flush busy",   512'(busy),      512'(1));
      count_busy("flush", 1'b1, nb, nr);
      chk("flush sweep_rsps", 512'(nr), 512'(0));
      do_cmd("post_flush C", mk(OP_LOOKUP, C_ADR, z, 0, 0, 0, z));
      do_cmd("post_flush D", mk(OP_LOOKUP, D_ADR, z, 0, 0, 0, z));

      // Reset the cycle after a WRITE acceptance.
      req_valid = 1'b1; req_op = OP_WRITE; req_addr = E_ADR; req_data = da;
      @(negedge clk);
      req_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      chk("mid_rst rsp_valid", 512'(rsp_valid), 512'(0));
      chk("mid_rst busy",      512'(busy),      512'(1));
      chk("mid_rst ready",     512'(req_ready), 512'(0));
      @(negedge clk);
      rst_n = 1'b1;
      count_busy("mid_rst", 1'b0, nb, nr);
      chk("mid_rst rsps", 512'(nr), 512'(0));
      do_cmd("post_rst E", mk(OP_LOOKUP, E_ADR, z, 0, 0, 0, z));

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/assoc_cache.md
# assoc_cache

Parametrised N-way set-associative lookup cache for the key-value path. It replaces the direct-mapped, fixed-size dual-port cache with configurable geometry, pseudo-LRU replacement, explicit invalidate, and a hardware flush sweep. It sits between the hash/lookup front end and the DRAM value store. A single command port carries lookups, fills and invalidates. Tag, valid and value live in per-way block RAM; pLRU state lives in flops.

## Interface
- C_ADDR_WIDTH, 32: full key/memory address width.
- C_SET_WIDTH, 8: set index width; 2**C_SET_WIDTH sets; index = req_addr[C_SET_WIDTH-1:0].
- C_DATA_WIDTH, 512: cached value width.
- C_NWAY, 2: associativity; legal values 1, 2, 4; any other value is an elaboration error.
- C_TAG_WIDTH, C_ADDR_WIDTH-C_SET_WIDTH: tag = req_addr[C_ADDR_WIDTH-1:C_SET_WIDTH].
- clk  in  1  single clock.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  pulse; invalidates the whole cache.
- busy  out  1  flush sweep in progress.
- req_valid  in  1  command valid.
- req_ready  out  1  command accepted when req_valid && req_ready at a clk edge.
- req_op  in  2  command: 0 LOOKUP, 1 WRITE, 2 INVAL, 3 reserved (treated as LOOKUP).
- req_addr  in  C_ADDR_WIDTH  key address.
- req_data  in  C_DATA_WIDTH  fill value (WRITE only).
- rsp_valid  out  1  one-cycle response strobe; no backpressure.
- rsp_op  out  2  echo of req_op.
- rsp_hit  out  1  a valid line with a matching tag was found.
- rsp_way  out  clog2(C_NWAY) (min 1)  way that hit, or was written.
- rsp_data  out  C_DATA_WIDTH  LOOKUP hit value; zero otherwise.
- rsp_evict  out  1  WRITE miss overwrote a valid line.

## Operation
- FSM states:
  - FLUSH: a set counter runs 0 to 2**C_SET_WIDTH-1, writing valid=0 to all ways and pLRU=0, one set per cycle. busy=1 and req_ready=0 throughout.
  - RUN: req_ready=1.
  - STALL: a 2-cycle counter with req_ready=0.
- Transitions:
  - Reset enters FLUSH with the counter at 0.
  - FLUSH goes to RUN after the last set is written.
  - In RUN, an accepted WRITE or INVAL enters STALL; STALL returns to RUN after 2 cycles.
  - flush asserted in RUN or STALL enters FLUSH after in-flight commands retire. The pipeline drains (2 cycles) before the sweep starts.
  - flush asserted during FLUSH is ignored.
- Pipeline:
  - S0: the set index addresses all way RAMs.
  - S1: RAM outputs are registered. Tags are compared and a way is selected. RAM and pLRU writes issue.
  - S2: the response is registered.
- LOOKUP:
  - hit: rsp_data = hit way value, and that way becomes MRU.
  - miss: rsp_hit=0, rsp_data=0, pLRU unchanged.
- WRITE victim selection, first match wins:
  - the hitting way (in-place update, rsp_hit=1);
  - otherwise the lowest-index invalid way;
  - otherwise the pLRU victim, which sets rsp_evict=1.
  - The written way becomes MRU.
- INVAL:
  - hit: clears that way's valid bit; pLRU unchanged.
  - miss: no state change, rsp_hit=0.
- pLRU: a tree of C_NWAY-1 bits per set. For C_NWAY=1 there is no state and the victim is always way 0.
- Tag matches in more than one way cannot occur by construction; if they do, the lowest index wins.

## Timing
- Latency: a command accepted at edge T produces rsp_valid high for exactly the cycle after edge T+2.
- LOOKUPs issue back-to-back at 1 per cycle.
- pLRU is read combinationally in S1, so consecutive lookups to the same set see each other's updates.
- RAM writes commit at edge T+2. The RAM is read-first on same-address collisions. The earliest next acceptance after a WRITE or INVAL is edge T+3.
- Reset values: req_ready=0, busy=1, rsp_valid=0, and every other rsp_* output 0. The FSM is in FLUSH with pipeline valids cleared.
- Reset asserted mid-operation aborts all in-flight commands; no rsp_valid is produced for them.
- Cold-start: 2**C_SET_WIDTH cycles of FLUSH before the first req_ready.

## Structure
- Package assoc_cache_pkg holds:
  - the op encodings (OP_LOOKUP, OP_WRITE, OP_INVAL);
  - the way-entry layout: valid bit, tag, data;
  - the pLRU update and victim functions, parametrised on C_NWAY.
- Sub-module assoc_cache_way_ram: a simple dual-port RAM, one write port and one read port, registered read output, read-first. One instance per way, each {valid, tag, data} wide and 2**C_SET_WIDTH deep. It holds no reset state; FLUSH initialises it.
- The top level owns the FSM, pipeline registers, compare/select logic and the pLRU flop array.

## Test plan
- Cold start with defaults, rst_n released -> busy high for 256 cycles, then req_ready=1. LOOKUP 0x00001234 -> rsp_hit=0 at acceptance+2.
- Fill then lookup:
  - WRITE 0x00001234 with data 0xAB..AB -> rsp_hit=0, rsp_way=0, rsp_evict=0.
  - req_ready low for 2 cycles.
  - LOOKUP of the same address -> rsp_hit=1, rsp_data=0xAB..AB, rsp_way=0.
- Replacement in set 0x34:
  - WRITE tags A, then B, then LOOKUP A, then WRITE C.
  - C replaces B: rsp_way=1, rsp_evict=1.
  - LOOKUP B -> miss; LOOKUP A -> hit.
- INVAL:
  - INVAL A -> rsp_hit=1; the following LOOKUP A -> miss.
  - A second INVAL A -> rsp_hit=0.
- Back-to-back LOOKUPs over 8 cycles to mixed hit/miss addresses -> 8 responses in order, 1 per cycle, each 2 cycles after its acceptance.
- Corner cases:
  - flush pulse mid-stream -> in-flight responses delivered, then busy for 256 cycles, then all lookups miss.
  - rst_n asserted the cycle after a WRITE acceptance -> no rsp_valid, and FLUSH restarts.
